// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester bundle (req_valid/req_data/req_ready) and output beat channel (out_valid/out_data/out_src/out_ready)
interface rr_mux_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W = 8
);
  localparam int SRC_W = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*W-1:0] req_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [SRC_W-1:0] out_src;
  modport master (
    output req_valid, req_data, out_ready,
    input req_ready, out_valid, out_data, out_src
  );
  modport slave (
    input req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N_REQ:1 mux into a one-entry registered output; ports clk, rst, bus (slave: req_valid/req_data in, req_ready out, out_valid/out_data/out_src out, out_ready in)
module rr_mux_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_REQ);
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] win;
  logic [SRC_W-1:0] idx;
  logic [SRC_W-1:0] src;
  logic [W-1:0] data;
  logic valid;
  logic any;
  logic load_en;
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(ptr) + k) % N_REQ);
      win = bus.req_valid[idx] ? idx : win;
    end
  end
  assign any = |bus.req_valid;
  assign load_en = !valid || bus.out_ready;
  assign bus.req_ready = (load_en && !rst && any) ? N_REQ'(1) << win : '0;
  assign bus.out_valid = valid;
  assign bus.out_data = data;
  assign bus.out_src = src;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data <= '0;
      src <= '0;
      ptr <= '0;
    end else if (load_en) begin
      valid <= any;
      if (any) begin
        data <= bus.req_data[int'(win) * W +: W];
        src <= win;
        ptr <= (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule
